// File: rtl/conv_frame_ctrl_pkg.sv
// Shared types and sizing helpers for the conv2 frame sequencer (package conv_ctrl_pkg).
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  localparam int DEF_COL = 12;
  localparam int DEF_ROW = 12;
  localparam int DEF_K   = 5;

  // Number of valid window positions along one axis.
  function automatic int out_dim(input int n, input int k);
    return n - k + 1;
  endfunction

  // Bits needed to index n items; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int OUT_X = out_dim(DEF_COL, DEF_K);
  localparam int OUT_Y = out_dim(DEF_ROW, DEF_K);
  localparam int N_OUT = OUT_X * OUT_Y;

endpackage

// File: rtl/conv_frame_ctrl_valid_delay_line.sv
// Fixed-depth shift register carrying {valid, win_valid} to align them with BRAM read data.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  logic [1:0] stage_q [DEPTH];

  // Reset clears every stage so no stale valid survives a mid-frame reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= 2'b00;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for conv2: streams one ROW x COL fmap into the core and counts its outputs.
// Optional drain watchdog is built when CONV_CTRL_WATCHDOG_EN is defined.
module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int COL     = DEF_COL,
  parameter int ROW     = DEF_ROW,
  parameter int K       = DEF_K,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_start,
  input  logic                            i_ds_ready,
  output logic                            o_rd_en,
  output logic [addr_w(ROW*COL)-1:0]      o_rd_addr,
  output logic                            o_core_valid,
  output logic                            o_win_valid,
  input  logic                            i_core_ot_valid,
  output logic [addr_w(ROW-K+1)-1:0]      o_ot_row,
  output logic [addr_w(COL-K+1)-1:0]      o_ot_col,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int NPIX = ROW * COL;
  localparam int OX   = out_dim(COL, K);
  localparam int OY   = out_dim(ROW, K);
  localparam int NOUT = OX * OY;
  localparam int AW   = addr_w(NPIX);
  localparam int RW   = addr_w(ROW);
  localparam int CLW  = addr_w(COL);
  localparam int ORW  = addr_w(OY);
  localparam int OCW  = addr_w(OX);
  localparam int CNTW = addr_w(NOUT + 1);

  ctrl_state_e     state_q;
  logic [AW-1:0]   pix_q;
  logic [RW-1:0]   row_q;
  logic [CLW-1:0]  col_q;
  logic            rd_en_q;
  logic [AW-1:0]   rd_addr_q;
  logic            win_q;
  logic [CNTW-1:0] out_cnt_q;
  logic [ORW-1:0]  ot_row_q;
  logic [OCW-1:0]  ot_col_q;
  logic            busy_q;
  logic            done_q;

  logic            start_go;
  logic            issuing;
  logic            count_ok;
  logic            win_d;
  logic            cur_last;
  logic [AW-1:0]   cur_pix;
  logic [RW-1:0]   cur_row;
  logic [CLW-1:0]  cur_col;
  logic [CNTW-1:0] out_cnt_d;
  logic [1:0]      dly_q;

`ifdef CONV_CTRL_WATCHDOG_EN
  localparam int WDW = addr_w(TIMEOUT);
  logic [WDW-1:0] wd_q;
  logic           err_q;
`endif

  // A start in IDLE issues pixel 0 on the same edge, so the pixel position restarts from zero.
  always_comb begin
    start_go  = (state_q == ST_IDLE) && i_start;
    issuing   = ((state_q == ST_ISSUE) || start_go) && i_ds_ready;
    cur_pix   = start_go ? '0 : pix_q;
    cur_row   = start_go ? '0 : row_q;
    cur_col   = start_go ? '0 : col_q;
    cur_last  = (cur_pix == AW'(NPIX - 1));
    win_d     = (cur_row >= RW'(K - 1)) && (cur_col >= CLW'(K - 1));
    count_ok  = i_core_ot_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) &&
                (out_cnt_q < CNTW'(NOUT));
    out_cnt_d = count_ok ? out_cnt_q + CNTW'(1) : out_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pix_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      win_q     <= 1'b0;
      out_cnt_q <= '0;
      ot_row_q  <= '0;
      ot_col_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CONV_CTRL_WATCHDOG_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      rd_en_q   <= issuing;
      win_q     <= issuing && win_d;
      done_q    <= 1'b0;
      out_cnt_q <= out_cnt_d;
`ifdef CONV_CTRL_WATCHDOG_EN
      wd_q      <= '0;
`endif

      // Output-point indices advance row-major over the OX x OY result grid.
      if (count_ok) begin
        if (ot_col_q == OCW'(OX - 1)) begin
          ot_col_q <= '0;
          ot_row_q <= (ot_row_q == ORW'(OY - 1)) ? '0 : ot_row_q + ORW'(1);
        end else begin
          ot_col_q <= ot_col_q + OCW'(1);
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q   <= ST_ISSUE;
            busy_q    <= 1'b1;
            out_cnt_q <= '0;
            ot_row_q  <= '0;
            ot_col_q  <= '0;
`ifdef CONV_CTRL_WATCHDOG_EN
            err_q     <= 1'b0;
`endif
          end
        end
        ST_DRAIN: begin
          if (out_cnt_d == CNTW'(NOUT)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
`ifdef CONV_CTRL_WATCHDOG_EN
          else if (i_core_ot_valid) begin
            wd_q <= '0;
          end else if (wd_q == WDW'(TIMEOUT - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
`endif
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
        end
      endcase

      // While stalled the address register shows the pixel that will be issued next.
      if ((state_q == ST_ISSUE) || start_go) begin
        rd_addr_q <= cur_pix;
        if (issuing) begin
          if (cur_last) begin
            pix_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= ST_DRAIN;
          end else begin
            pix_q <= cur_pix + AW'(1);
            if (cur_col == CLW'(COL - 1)) begin
              col_q <= '0;
              row_q <= cur_row + RW'(1);
            end else begin
              col_q <= cur_col + CLW'(1);
              row_q <= cur_row;
            end
          end
        end else begin
          pix_q <= cur_pix;
          row_q <= cur_row;
          col_q <= cur_col;
        end
      end
    end
  end

  valid_delay_line #(
    .DEPTH (RD_LAT)
  ) u_valid_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   ({rd_en_q, win_q}),
    .q_o   (dly_q)
  );

  assign o_rd_en      = rd_en_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_core_valid = dly_q[1];
  assign o_win_valid  = dly_q[0];
  assign o_ot_row     = ot_row_q;
  assign o_ot_col     = ot_col_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
`ifdef CONV_CTRL_WATCHDOG_EN
  assign o_err        = err_q;
`else
  assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl with a fixed-latency core model; watchdog expectations follow CONV_CTRL_WATCHDOG_EN.
module tb_conv_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic       i_ds_ready;
  logic       coreOtValid;
  logic       o_rd_en;
  logic [7:0] o_rd_addr;
  logic       o_core_valid;
  logic       o_win_valid;
  logic [2:0] o_ot_row;
  logic [2:0] o_ot_col;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [19:0] outs;

  int total = 0;
  int bad   = 0;

  int rdCount, addrErrs, holdErrs, stallCycles, cvCount, winCount, firstWin;
  int doneCount, outsAtDone, outCount, outLimit;
  logic [2:0] pipe;
  logic [2:0] obsRow [64];
  logic [2:0] obsCol [64];

  always #5 clk = ~clk;

  conv_frame_ctrl #(
    .COL     (12),
    .ROW     (12),
    .K       (5),
    .RD_LAT  (1),
    .TIMEOUT (20)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (i_start),
    .i_ds_ready      (i_ds_ready),
    .o_rd_en         (o_rd_en),
    .o_rd_addr       (o_rd_addr),
    .o_core_valid    (o_core_valid),
    .o_win_valid     (o_win_valid),
    .i_core_ot_valid (coreOtValid),
    .o_ot_row        (o_ot_row),
    .o_ot_col        (o_ot_col),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err)
  );

  assign outs = {o_rd_en, o_core_valid, o_win_valid, o_busy, o_done, o_err,
                 o_rd_addr, o_ot_row, o_ot_col};

  // Monitor plus core model: every window pixel yields one output point three cycles later.
  always @(negedge clk) begin
    if (reset) begin
      pipe        = 3'b000;
      coreOtValid = 1'b0;
    end else begin
      if (o_rd_en) begin
        if (o_rd_addr !== rdCount[7:0]) addrErrs++;
        rdCount++;
      end else if (o_busy && rdCount < 144) begin
        stallCycles++;
        if (o_rd_addr !== rdCount[7:0]) holdErrs++;
      end
      if (o_core_valid) begin
        if (o_win_valid) begin
          if (winCount == 0) firstWin = cvCount;
          winCount++;
        end
        cvCount++;
      end
      if (o_done) begin
        doneCount++;
        outsAtDone = outCount;
      end
      coreOtValid = pipe[2] && (outCount < outLimit);
      pipe = {pipe[1:0], o_core_valid && o_win_valid};
      if (coreOtValid) begin
        if (outCount < 64) begin
          obsRow[outCount] = o_ot_row;
          obsCol[outCount] = o_ot_col;
        end
        outCount++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clearStats();
    rdCount = 0; addrErrs = 0; holdErrs = 0; stallCycles = 0; cvCount = 0;
    winCount = 0; firstWin = -1; doneCount = 0; outsAtDone = 0; outCount = 0;
    outLimit = 1000;
  endtask

  task automatic applyStimulus();
    clearStats();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (doneCount == 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
  endtask

  task automatic waitReads(input int target, input int budget);
    int n = 0;
    while (rdCount < target && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b0; i_ds_ready = 1'b1;
    clearStats();
    tick(); tick();
    total++;
    if (outs !== 20'd0) begin
      bad++; $display("[TB] FAIL reset_outputs got=%h want=%h", outs, 20'd0);
    end
    reset = 1'b0;
    tick(); tick();
    total++;
    if (outs !== 20'd0) begin
      bad++; $display("[TB] FAIL idle_outputs got=%h want=%h", outs, 20'd0);
    end
  endtask

  task automatic test_basic_frame();
    applyStimulus();
    waitDone(400);
    total++; if (rdCount !== 144) begin bad++; $display("[TB] FAIL basic_reads got=%0d want=144", rdCount); end
    total++; if (addrErrs !== 0) begin bad++; $display("[TB] FAIL basic_addr_order got=%0d want=0", addrErrs); end
    total++; if (firstWin !== 52) begin bad++; $display("[TB] FAIL basic_first_win got=%0d want=52", firstWin); end
    total++; if (winCount !== 64) begin bad++; $display("[TB] FAIL basic_win_count got=%0d want=64", winCount); end
    total++; if (doneCount !== 1) begin bad++; $display("[TB] FAIL basic_done_count got=%0d want=1", doneCount); end
    total++; if (outsAtDone !== 64) begin bad++; $display("[TB] FAIL basic_outs_at_done got=%0d want=64", outsAtDone); end
    total++; if (stallCycles !== 0) begin bad++; $display("[TB] FAIL basic_stall_cycles got=%0d want=0", stallCycles); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_after got=%b want=0", o_busy); end
  endtask

  task automatic test_output_index();
    int idx[4]  = '{0, 7, 8, 63};
    int expR[4] = '{0, 0, 1, 7};
    int expC[4] = '{0, 7, 0, 7};
    applyStimulus();
    waitDone(400);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obsRow[idx[i]] !== 3'(expR[i]) || obsCol[idx[i]] !== 3'(expC[i])) begin
        bad++;
        $display("[TB] FAIL ot_index_%0d got=(%0d,%0d) want=(%0d,%0d)", idx[i],
                 obsRow[idx[i]], obsCol[idx[i]], expR[i], expC[i]);
      end
    end
  endtask

  task automatic test_stall();
    applyStimulus();
    waitReads(30, 100);
    i_ds_ready = 1'b0;
    repeat (10) tick();
    i_ds_ready = 1'b1;
    waitDone(400);
    total++; if (rdCount !== 144) begin bad++; $display("[TB] FAIL stall_reads got=%0d want=144", rdCount); end
    total++; if (addrErrs !== 0) begin bad++; $display("[TB] FAIL stall_addr_order got=%0d want=0", addrErrs); end
    total++; if (stallCycles !== 10) begin bad++; $display("[TB] FAIL stall_cycles got=%0d want=10", stallCycles); end
    total++; if (holdErrs !== 0) begin bad++; $display("[TB] FAIL stall_addr_hold got=%0d want=0", holdErrs); end
    total++; if (doneCount !== 1 || outsAtDone !== 64) begin
      bad++; $display("[TB] FAIL stall_done got=%0d/%0d want=1/64", doneCount, outsAtDone);
    end
  endtask

  task automatic test_ignored_start();
    applyStimulus();
    waitReads(80, 200);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    waitDone(400);
    total++; if (rdCount !== 144 || addrErrs !== 0) begin
      bad++; $display("[TB] FAIL ign_start_reads got=%0d/%0d want=144/0", rdCount, addrErrs);
    end
    total++; if (winCount !== 64 || firstWin !== 52) begin
      bad++; $display("[TB] FAIL ign_start_win got=%0d/%0d want=64/52", winCount, firstWin);
    end
    total++; if (doneCount !== 1 || outsAtDone !== 64) begin
      bad++; $display("[TB] FAIL ign_start_done got=%0d/%0d want=1/64", doneCount, outsAtDone);
    end
  endtask

  task automatic test_reset_mid_frame();
    applyStimulus();
    waitReads(144, 300);
    total++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_reset_in_drain got=%b%b want=10", o_busy, o_done);
    end
    reset = 1'b1;
    #1;
    total++; if (outs !== 20'd0) begin bad++; $display("[TB] FAIL mid_reset_async got=%h want=%h", outs, 20'd0); end
    tick();
    total++; if (outs !== 20'd0) begin bad++; $display("[TB] FAIL mid_reset_next got=%h want=%h", outs, 20'd0); end
    reset = 1'b0;
    tick();
    applyStimulus();
    waitDone(400);
    total++; if (rdCount !== 144 || addrErrs !== 0) begin
      bad++; $display("[TB] FAIL after_reset_reads got=%0d/%0d want=144/0", rdCount, addrErrs);
    end
    total++; if (doneCount !== 1 || outsAtDone !== 64) begin
      bad++; $display("[TB] FAIL after_reset_done got=%0d/%0d want=1/64", doneCount, outsAtDone);
    end
  endtask

  task automatic test_watchdog();
    applyStimulus();
    outLimit = 40;
    repeat (220) tick();
    total++; if (outCount !== 40) begin bad++; $display("[TB] FAIL wd_outputs got=%0d want=40", outCount); end
    total++; if (doneCount !== 0) begin bad++; $display("[TB] FAIL wd_no_done got=%0d want=0", doneCount); end
`ifdef CONV_CTRL_WATCHDOG_EN
    total++; if (o_err !== 1'b1) begin bad++; $display("[TB] FAIL wd_err got=%b want=1", o_err); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL wd_idle_busy got=%b want=0", o_busy); end
`else
    total++; if (o_err !== 1'b0) begin bad++; $display("[TB] FAIL wd_err got=%b want=0", o_err); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL wd_busy_hold got=%b want=1", o_busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_output_index();
    test_stall();
    test_ignored_start();
    test_reset_mid_frame();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_frame_ctrl.md
# conv_frame_ctrl

Frame sequencer for the conv2 stage. On a start pulse it streams one ROW×COL multi-channel feature map from the input fmap BRAM into the convolution core, one pixel per cycle. It flags pixels that complete a valid KX×KY window, pauses issue under downstream stall, and counts the core's output points. When the last output point has been received it signals done.

## Interface
**Parameters**
- `COL`, default 12: feature-map width.
- `ROW`, default 12: feature-map height.
- `K`, default 5: kernel size (square).
- `RD_LAT`, default 1: BRAM read latency in cycles.
- `TIMEOUT`, default 255: drain watchdog limit in cycles (used only with the macro).

**Ports**
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `i_start` in 1: start pulse; ignored unless in IDLE.
- `i_ds_ready` in 1: downstream can accept; low pauses issue.
- `o_rd_en` in-BRAM out 1: BRAM read enable.
- `o_rd_addr` out `$clog2(ROW*COL)`: BRAM read address, `row*COL+col`.
- `o_core_valid` out 1: drives the core `i_in_valid`; aligned with BRAM data, i.e. `o_rd_en` delayed by `RD_LAT`.
- `o_win_valid` out 1: the pixel now presented to the core completes a full window.
- `i_core_ot_valid` in 1: core output point valid.
- `o_ot_row` out `$clog2(ROW-K+1)`: output-point row index of the current/next output.
- `o_ot_col` out `$clog2(COL-K+1)`: output-point column index of the current/next output.
- `o_busy` out 1: high from ISSUE through DRAIN.
- `o_done` out 1: one-cycle pulse when the frame is complete.
- `o_err` out 1: watchdog flag; sticky until next `i_start`. Tied 0 when the macro is absent.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE → ISSUE on `i_start`. Clears the pixel counters, output counters and `o_err`.
  - ISSUE: each cycle `i_ds_ready` is high, assert `o_rd_en`, then advance `col`. At `COL-1`, wrap `col` to 0 and increment `row`.
  - ISSUE → DRAIN after pixel `ROW*COL-1` is issued.
  - DRAIN → DONE when the output count reaches `(ROW-K+1)*(COL-K+1)`.
  - DONE → IDLE unconditionally after one cycle; `o_done` is high during DONE.
- `o_win_valid` is delayed with the same `RD_LAT` pipeline as `o_core_valid`. It is high for a pixel at (r,c) when `r>=K-1 && c>=K-1`.
- Output counter:
  - Increments on each `i_core_ot_valid` while busy.
  - `o_ot_col` wraps at `COL-K`; `o_ot_row` increments on each wrap.
  - `i_core_ot_valid` outside ISSUE/DRAIN is ignored.
- Stall:
  - `i_ds_ready` low freezes issue only; in-flight pixels and core outputs still complete.
  - Downstream must absorb up to `RD_LAT` + core latency points after deasserting ready.
- `i_start` during ISSUE, DRAIN or DONE is ignored.
- Output arriving in the same cycle as the last issue: count it; no state skip.
- Final output arriving in the same cycle the last pixel is issued: the FSM still passes through DRAIN for one cycle.

## Timing
- Reset values: FSM in IDLE; all counters 0; `o_rd_en`, `o_core_valid`, `o_win_valid`, `o_busy`, `o_done`, `o_err` all 0; `o_rd_addr` 0.
- `o_rd_en` is asserted the cycle after `i_start` is sampled.
- `o_core_valid` = `o_rd_en` delayed by `RD_LAT` cycles.
- Throughput: 1 pixel/cycle with no stall, giving `ROW*COL` issue cycles.
- `reset` mid-frame: immediately returns all state to reset values; the valid pipeline is flushed, so no stale `o_core_valid` appears.
- All outputs are registered.

## Configuration
- `CONV_CTRL_WATCHDOG_EN`
  - Defined: in DRAIN, a counter reloads on each `i_core_ot_valid`. If `TIMEOUT` cycles pass with no output, set `o_err` and go to IDLE with no `o_done`.
  - Undefined: no counter is built, DRAIN waits indefinitely, and `o_err` is constant 0.

## Structure
- Shared package `conv_ctrl_pkg`:
  - FSM state enum.
  - Default `COL`/`ROW`/`K`.
  - Derived `OUT_X = COL-K+1`, `OUT_Y = ROW-K+1`, `N_OUT = OUT_X*OUT_Y`.
  - Address width function.
- One sub-module, `valid_delay_line`: a `RD_LAT`-deep shift register carrying {valid, win_valid} with async reset.

## Test plan
- **Basic frame.** Default params, `i_start`, `i_ds_ready`=1, core model emits 64 outputs. Required:
  - 144 `o_rd_en` cycles with addresses 0..143 in order.
  - First `o_win_valid` on pixel 52 (r4,c4).
  - Exactly 64 `o_win_valid`.
  - `o_done` pulses once after the 64th output.
- **Stall.** Drop `i_ds_ready` for 10 cycles at pixel 30. Required: address holds at 30 during the stall, resumes at 30, 144 reads total, `o_done` still after 64 outputs.
- **Output indexing.** Check `o_ot_row`/`o_ot_col` at outputs 0, 7, 8 and 63. Required: (0,0), (0,7), (1,0), (7,7).
- **Ignored start.** Pulse `i_start` mid-ISSUE at pixel 80. Required: no restart; sequence identical to the basic frame.
- **Reset mid-frame.** Assert `reset` during DRAIN. Required: all outputs 0 next cycle. A following `i_start` runs a clean full frame.
- **Watchdog.** With `CONV_CTRL_WATCHDOG_EN` and `TIMEOUT`=20, the core stops after 40 outputs. Required: `o_err`=1 about 20 cycles later, no `o_done`, state IDLE. Without the macro, `o_busy` stays high.
